// File: rtl/cardinal_nic.sv
// Network interface between the cardinal CPU EX_MEM stage and a router port.
// Each direction holds one packet guarded by a full flag; output obeys VC polarity.
module cardinal_nic (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic [0:63] d_in,
  output logic [0:63] d_out,
  input  logic        nicEn,
  input  logic        nicEnWr,
  input  logic        net_si,
  output logic        net_ri,
  input  logic [0:63] net_di,
  output logic        net_so,
  input  logic        net_ro,
  output logic [0:63] net_do,
  input  logic        net_polarity
);

  localparam logic [1:0] ADDR_IN_BUF  = 2'b00;
  localparam logic [1:0] ADDR_IN_STS  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF = 2'b10;
  localparam logic [1:0] ADDR_OUT_STS = 2'b11;

  logic [0:63] in_buf_q,  in_buf_d;
  logic [0:63] out_buf_q, out_buf_d;
  logic        in_full_q,  in_full_d;
  logic        out_full_q, out_full_d;

  logic cpu_rd, cpu_wr;
  logic rd_in_buf, wr_out_buf;
  logic accept_in, send_out;

  assign cpu_rd     = nicEn & ~nicEnWr;
  assign cpu_wr     = nicEn &  nicEnWr;
  assign rd_in_buf  = cpu_rd & (addr == ADDR_IN_BUF);
  assign wr_out_buf = cpu_wr & (addr == ADDR_OUT_BUF);

  // Bit 0 of the packet selects the VC; it only leaves when it matches the router.
  assign net_ri    = ~in_full_q;
  assign accept_in = net_si & ~in_full_q;
  assign send_out  = out_full_q & net_ro & (out_buf_q[0] == net_polarity);
  assign net_so    = send_out;
  assign net_do    = out_buf_q;

  always_comb begin
    d_out = 64'b0;
    if (cpu_rd) begin
      case (addr)
        ADDR_IN_BUF:  d_out = in_buf_q;
        ADDR_IN_STS:  d_out = {63'b0, in_full_q};
        ADDR_OUT_STS: d_out = {63'b0, out_full_q};
        default:      d_out = 64'b0;
      endcase
    end
  end

  // Accept and CPU clear are mutually exclusive: accept needs empty, clear needs full.
  always_comb begin
    in_buf_d  = in_buf_q;
    in_full_d = in_full_q;
    if (accept_in) begin
      in_buf_d  = net_di;
      in_full_d = 1'b1;
    end else if (rd_in_buf && in_full_q) begin
      in_full_d = 1'b0;
    end
  end

  // A write landing while full (including the send cycle) is dropped.
  always_comb begin
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    if (send_out) begin
      out_full_d = 1'b0;
    end else if (wr_out_buf && !out_full_q) begin
      out_buf_d  = d_in;
      out_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_buf_q   <= 64'b0;
      out_buf_q  <= 64'b0;
      in_full_q  <= 1'b0;
      out_full_q <= 1'b0;
    end else begin
      in_buf_q   <= in_buf_d;
      out_buf_q  <= out_buf_d;
      in_full_q  <= in_full_d;
      out_full_q <= out_full_d;
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed vector bench for cardinal_nic: one table row per clock cycle plus a reset sequence.
module tb_cardinal_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn, nicEnWr;
  logic        net_si, net_ri;
  logic [63:0] net_di;
  logic        net_so, net_ro;
  logic [63:0] net_do;
  logic        net_polarity;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cardinal_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicEnWr      (nicEnWr),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  a;
    logic        en;
    logic        wr;
    logic [63:0] din;
    logic        si;
    logic [63:0] di;
    logic        ro;
    logic        pol;
    logic        chk_dout;
    logic [63:0] e_dout;
    logic        e_ri;
    logic        e_so;
    logic [63:0] e_do;
  } vec_t;

  localparam logic [63:0] P1 = 64'hA5A5_0000_1234_5678;
  localparam logic [63:0] P2 = 64'h8000_0000_0000_00FF;
  localparam logic [63:0] P3 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] P4 = 64'h0000_0000_0000_0042;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [1:0] a, input logic en, input logic wr,
                              input logic [63:0] din, input logic si, input logic [63:0] di,
                              input logic ro, input logic pol, input logic cd,
                              input logic [63:0] ed, input logic eri, input logic eso,
                              input logic [63:0] edo);
    vec_t v;
    v.rst = rst; v.a = a; v.en = en; v.wr = wr; v.din = din; v.si = si; v.di = di;
    v.ro = ro; v.pol = pol; v.chk_dout = cd; v.e_dout = ed; v.e_ri = eri; v.e_so = eso;
    v.e_do = edo;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; addr = v.a; nicEn = v.en; nicEnWr = v.wr; d_in = v.din;
    net_si = v.si; net_di = v.di; net_ro = v.ro; net_polarity = v.pol;
  endtask

  initial begin
    //            rst a     en wr din   si di  ro pol cd dout  ri so do
    vecs.push_back(mk(0, 2'b00, 0, 0, 0,    0, 0,  0, 0, 1, 0,    1, 0, 0));   // idle after reset
    vecs.push_back(mk(0, 2'b01, 1, 0, 0,    0, 0,  0, 0, 1, 0,    1, 0, 0));   // in status 0
    vecs.push_back(mk(0, 2'b11, 1, 0, 0,    0, 0,  0, 0, 1, 0,    1, 0, 0));   // out status 0
    vecs.push_back(mk(0, 2'b00, 0, 0, 0,    1, P1, 0, 0, 1, 0,    1, 0, 0));   // router delivers P1
    vecs.push_back(mk(0, 2'b01, 1, 0, 0,    0, 0,  0, 0, 1, 1,    0, 0, 0));   // in full, ri low
    vecs.push_back(mk(0, 2'b00, 1, 0, 0,    0, 0,  0, 0, 1, P1,   0, 0, 0));   // read P1, clears
    vecs.push_back(mk(0, 2'b01, 1, 0, 0,    0, 0,  0, 0, 1, 0,    1, 0, 0));   // status back to 0
    vecs.push_back(mk(0, 2'b00, 1, 0, 0,    0, 0,  0, 0, 1, P1,   1, 0, 0));   // stale read
    vecs.push_back(mk(0, 2'b10, 1, 1, P2,   0, 0,  1, 0, 0, 0,    1, 0, 0));   // write P2
    vecs.push_back(mk(0, 2'b11, 1, 0, 0,    0, 0,  1, 0, 1, 1,    1, 0, P2));  // polarity mismatch
    vecs.push_back(mk(0, 2'b10, 1, 1, 64'h1,0, 0,  0, 1, 0, 0,    1, 0, P2));  // write while full
    vecs.push_back(mk(0, 2'b10, 1, 0, 0,    0, 0,  0, 1, 1, 0,    1, 0, P2));  // addr 10 reads 0
    vecs.push_back(mk(0, 2'b10, 1, 1, 64'h1,0, 0,  1, 1, 0, 0,    1, 1, P2));  // send + dropped write
    vecs.push_back(mk(0, 2'b11, 1, 0, 0,    0, 0,  1, 1, 1, 0,    1, 0, P2));  // sent, out empty
    vecs.push_back(mk(0, 2'b00, 0, 0, 0,    1, P1, 1, 1, 1, 0,    1, 0, P2));  // capture P1
    vecs.push_back(mk(0, 2'b00, 0, 0, 0,    1, P3, 1, 1, 1, 0,    0, 0, P2));  // P3 held off
    vecs.push_back(mk(0, 2'b00, 1, 0, 0,    1, P3, 1, 1, 1, P1,   0, 0, P2));  // read P1, clear
    vecs.push_back(mk(0, 2'b01, 1, 0, 0,    1, P3, 1, 1, 1, 0,    1, 0, P2));  // P3 captured now
    vecs.push_back(mk(0, 2'b00, 1, 0, 0,    0, 0,  1, 1, 1, P3,   0, 0, P2));  // read P3
    vecs.push_back(mk(0, 2'b11, 1, 1, ONES, 0, 0,  1, 1, 0, 0,    1, 0, P2));  // write 11 ignored
    vecs.push_back(mk(0, 2'b11, 1, 0, 0,    0, 0,  1, 1, 1, 0,    1, 0, P2));  // still empty
    vecs.push_back(mk(0, 2'b10, 1, 1, P4,   0, 0,  0, 0, 0, 0,    1, 0, P2));  // write VC0 packet
    vecs.push_back(mk(0, 2'b11, 0, 0, 0,    0, 0,  1, 0, 1, 0,    1, 1, P4));  // sent on pol 0
    vecs.push_back(mk(0, 2'b11, 1, 0, 0,    0, 0,  1, 0, 1, 0,    1, 0, P4));  // one cycle only

    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #2;
      if (vecs[i].chk_dout) check($sformatf("v%0d d_out", i), d_out, vecs[i].e_dout);
      check($sformatf("v%0d net_ri", i), {63'b0, net_ri}, {63'b0, vecs[i].e_ri});
      check($sformatf("v%0d net_so", i), {63'b0, net_so}, {63'b0, vecs[i].e_so});
      check($sformatf("v%0d net_do", i), net_do, vecs[i].e_do);
      @(posedge clk);
      #1;
    end

    // Fill both channels, then reset with both packets pending.
    drive(mk(0, 2'b10, 1, 1, P2, 1, P1, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    nicEn = 1'b0; net_si = 1'b0;
    #1;
    check("full in ri", {63'b0, net_ri}, 64'd0);
    check("full out do", net_do, P2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; net_ro = 1'b1; net_polarity = 1'b1;
    #1;
    check("rst net_so", {63'b0, net_so}, 64'd0);
    check("rst net_ri", {63'b0, net_ri}, 64'd1);
    check("rst net_do", net_do, 64'd0);
    check("rst d_out idle", d_out, 64'd0);
    nicEn = 1'b1; nicEnWr = 1'b0; addr = 2'b01;
    #1;
    check("rst in status", d_out, 64'd0);
    addr = 2'b11;
    #1;
    check("rst out status", d_out, 64'd0);
    addr = 2'b00;
    #1;
    check("rst in_buf", d_out, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
